// File: rtl/data_loader_ascon_pkg.sv
// Shared types and constants for the ASCON message loader: FSM states,
// block count and the per-block byte-type encoding.
package ascon_pack;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_WAIT,
      ST_ISSUE,
      ST_DONE
   } loader_state_e;

   localparam int NB_BLOCKS = 3;

   localparam logic BLK_TYPE_AD = 1'b0;
   localparam logic BLK_TYPE_PT = 1'b1;

   // Block 0 carries associated data, all later blocks carry plaintext.
   function automatic logic expected_type(input logic [1:0] block_idx);
      return (block_idx == 2'd0) ? BLK_TYPE_AD : BLK_TYPE_PT;
   endfunction

endpackage

// File: rtl/data_loader_ascon_packer.sv
// Fill buffer for one 64-bit block: packs bytes big-endian, inserts the
// padding byte on an early last, and pre-loads a pad-only block when asked.
module packer_octets_ascon #(
   parameter logic [7:0] PAD_BYTE = 8'h80
) (
   input  logic        clk_i,
   input  logic        resetb_i,
   input  logic        clear_i,
   input  logic        release_i,
   input  logic        accept_i,
   input  logic [7:0]  byte_i,
   input  logic        last_i,
   input  logic [1:0]  block_idx_i,
   output logic [63:0] fill_o,
   output logic        complete_o,
   output logic        completing_o
);

   logic [63:0] fill_q, fill_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        complete_q, complete_d;
   logic        pad_blk_q, pad_blk_d;

   always_comb begin
      fill_d       = fill_q;
      cnt_d        = cnt_q;
      complete_d   = complete_q;
      pad_blk_d    = pad_blk_q;
      completing_o = accept_i && ((cnt_q == 4'd7) || last_i);

      if (clear_i) begin
         fill_d     = '0;
         cnt_d      = '0;
         complete_d = 1'b0;
         pad_blk_d  = 1'b0;
      end else if (release_i) begin
         // A last byte in block 1 leaves block 2 as padding only, ready at once.
         fill_d     = pad_blk_q ? {PAD_BYTE, 56'd0} : 64'd0;
         cnt_d      = '0;
         complete_d = pad_blk_q;
         pad_blk_d  = 1'b0;
      end else if (accept_i) begin
         for (int k = 0; k < 8; k++) begin
            if (cnt_q == 4'(k))
               fill_d[63-8*k -: 8] = byte_i;
            else if (last_i && (cnt_q + 4'd1 == 4'(k)))
               fill_d[63-8*k -: 8] = PAD_BYTE;
         end
         cnt_d      = cnt_q + 4'd1;
         complete_d = completing_o;
         if (last_i && (block_idx_i == 2'd1))
            pad_blk_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!resetb_i) begin
         fill_q     <= '0;
         cnt_q      <= '0;
         complete_q <= 1'b0;
         pad_blk_q  <= 1'b0;
      end else begin
         fill_q     <= fill_d;
         cnt_q      <= cnt_d;
         complete_q <= complete_d;
         pad_blk_q  <= pad_blk_d;
      end
   end

   assign fill_o     = fill_q;
   assign complete_o = complete_q;

endmodule

// File: rtl/data_loader_ascon.sv
// ASCON data loader: packs AD/PT bytes into three 64-bit blocks and releases
// each on its control-FSM strobe. Define ASCON_LOADER_ERR_EN for byte-type errors.
module data_loader_ascon
   import ascon_pack::*;
#(
   parameter logic [7:0] PAD_BYTE = 8'h80
) (
   input  logic        clock_i,
   input  logic        resetb_i,
   input  logic        start_i,
   input  logic [7:0]  byte_i,
   input  logic        byte_valid_i,
   input  logic        byte_last_i,
   input  logic        byte_type_i,
   input  logic        end_init_i,
   input  logic        end_associate_i,
   input  logic        end_cipher_i,
   output logic        ready_o,
   output logic [63:0] data_o,
   output logic        data_valid_o,
   output logic        done_o,
   output logic        err_o
);

   loader_state_e state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [63:0]   data_q, data_d;
   logic [63:0]   fill;
   logic          complete, completing, accept, strobe;

   assign ready_o      = (state_q == ST_FILL) && !complete;
   assign accept       = byte_valid_i && ready_o && !start_i;
   assign data_valid_o = (state_q == ST_ISSUE);
   assign done_o       = (state_q == ST_DONE);
   assign data_o       = data_q;

   packer_octets_ascon #(.PAD_BYTE(PAD_BYTE)) u_packer (
      .clk_i        (clock_i),
      .resetb_i     (resetb_i),
      .clear_i      (start_i),
      .release_i    (state_q == ST_ISSUE),
      .accept_i     (accept),
      .byte_i       (byte_i),
      .last_i       (byte_last_i),
      .block_idx_i  (idx_q),
      .fill_o       (fill),
      .complete_o   (complete),
      .completing_o (completing)
   );

   always_comb begin
      case (idx_q)
         2'd0:    strobe = end_init_i;
         2'd1:    strobe = end_associate_i;
         default: strobe = end_cipher_i;
      endcase
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE:  ;
         ST_FILL:  if (completing || complete) state_d = ST_WAIT;
         ST_WAIT: begin
            if (strobe) begin
               state_d = ST_ISSUE;
               data_d  = fill;
            end
         end
         ST_ISSUE: begin
            idx_d   = idx_q + 2'd1;
            state_d = (idx_q < 2'(NB_BLOCKS - 1)) ? ST_FILL : ST_DONE;
         end
         ST_DONE:  ;
         default:  state_d = ST_IDLE;
      endcase
      // A start from any state restarts the message; the last issued block stays visible.
      if (start_i) begin
         state_d = ST_FILL;
         idx_d   = '0;
         data_d  = data_q;
      end
   end

   always_ff @(posedge clock_i) begin
      if (!resetb_i) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
      end
   end

`ifdef ASCON_LOADER_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (start_i)
         err_d = 1'b0;
      else if (accept && (byte_type_i != expected_type(idx_q)))
         err_d = 1'b1;
   end

   always_ff @(posedge clock_i) begin
      if (!resetb_i)
         err_q <= 1'b0;
      else
         err_q <= err_d;
   end

   assign err_o = err_q;
`else
   logic unused_byte_type;
   assign unused_byte_type = byte_type_i;
   assign err_o = 1'b0;
`endif

endmodule
